ravenoc_edge_sink: RTL and testbench

//  Active terminator for an unused mesh-edge router port. It accepts every flit sent out of that

---
 rtl/ravenoc_edge_sink.sv | 211 +++++++++++++++++++++
 tb/tb_ravenoc_edge_sink.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ravenoc_edge_sink.sv
// Active terminator for an unused mesh-edge router port: accepts every flit, checks
// per-VC packet framing, counts flits/packets and latches the first framing error.
module ravenoc_edge_sink #(
   parameter int FLIT_WIDTH = 34,
   parameter int X_W        = 2,
   parameter int Y_W        = 2,
   parameter int PKT_W      = 8,
   parameter int N_VC       = 3,
   localparam int VC_W      = (N_VC > 1) ? $clog2(N_VC) : 1
) (
   input  logic                  clk_noc,
   input  logic                  arst_noc,
   input  logic                  en_i,
   input  logic                  clr_i,
   input  logic [FLIT_WIDTH-1:0] flit_i,
   input  logic                  valid_i,
   input  logic [VC_W-1:0]       vc_id_i,
   output logic [N_VC-1:0]       ready_o,
   output logic [31:0]           flit_cnt_o,
   output logic [15:0]           pkt_cnt_o,
   output logic                  err_o,
   output logic [1:0]            err_code_o,
   output logic [VC_W-1:0]       err_vc_o,
   output logic [FLIT_WIDTH-1:0] err_hdr_o
);

   typedef enum logic [1:0] {
      FT_HEAD      = 2'b00,
      FT_BODY      = 2'b01,
      FT_TAIL      = 2'b10,
      FT_HEAD_TAIL = 2'b11
   } flit_type_e;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'b00,
      ERR_ORPHAN = 2'b01,
      ERR_TRUNC  = 2'b10,
      ERR_LEN    = 2'b11
   } err_code_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PAYLOAD = 1'b1
   } vc_state_e;

   localparam int SIZE_MSB = FLIT_WIDTH - 3 - X_W - Y_W;

   vc_state_e             state_q [N_VC];
   vc_state_e             state_d [N_VC];
   logic [PKT_W-1:0]      rem_q   [N_VC];
   logic [PKT_W-1:0]      rem_d   [N_VC];
   logic [FLIT_WIDTH-1:0] head_q  [N_VC];
   logic [FLIT_WIDTH-1:0] head_d  [N_VC];

   logic [N_VC-1:0]       ready_q, ready_d, hit;
   logic [31:0]           flit_cnt_q, flit_cnt_d;
   logic [15:0]           pkt_cnt_q, pkt_cnt_d;
   logic                  err_q, err_d;
   err_code_e             err_code_q, err_code_d;
   logic [VC_W-1:0]       err_vc_q, err_vc_d;
   logic [FLIT_WIDTH-1:0] err_hdr_q, err_hdr_d;

   flit_type_e            ftype;
   logic [PKT_W-1:0]      fsize;
   logic                  accept, pkt_done, start_new;
   err_code_e             err_code_n;
   logic [FLIT_WIDTH-1:0] err_hdr_n;

   assign ftype = flit_type_e'(flit_i[FLIT_WIDTH-1 -: 2]);
   assign fsize = flit_i[SIZE_MSB -: PKT_W];

   // Out-of-range VC ids match no lane, so they are never accepted.
   always_comb begin
      hit = '0;
      for (int unsigned v = 0; v < N_VC; v++) begin
         hit[v] = valid_i && ready_q[v] && (vc_id_i == VC_W'(v));
      end
   end

   assign accept  = |hit;
   assign ready_d = {N_VC{en_i}};

   always_comb begin
      pkt_done   = 1'b0;
      start_new  = 1'b0;
      err_code_n = ERR_NONE;
      err_hdr_n  = '0;
      for (int unsigned v = 0; v < N_VC; v++) begin
         state_d[v] = state_q[v];
         rem_d[v]   = rem_q[v];
         head_d[v]  = head_q[v];
         if (hit[v]) begin
            start_new = (state_q[v] == ST_IDLE);
            if (state_q[v] == ST_PAYLOAD) begin
               state_d[v] = ST_IDLE;
               case (ftype)
                  FT_BODY: begin
                     if (rem_q[v] > PKT_W'(1)) begin
                        rem_d[v]   = rem_q[v] - PKT_W'(1);
                        state_d[v] = ST_PAYLOAD;
                     end else begin
                        err_code_n = ERR_LEN;
                        err_hdr_n  = head_q[v];
                     end
                  end
                  FT_TAIL: begin
                     if (rem_q[v] == PKT_W'(1)) begin
                        pkt_done = 1'b1;
                     end else begin
                        err_code_n = ERR_LEN;
                        err_hdr_n  = head_q[v];
                     end
                  end
                  default: begin
                     err_code_n = ERR_TRUNC;
                     err_hdr_n  = head_q[v];
                     start_new  = 1'b1;
                  end
               endcase
            end
            // A truncating head also opens a new packet; TRUNC outranks its own LEN.
            if (start_new) begin
               case (ftype)
                  FT_HEAD_TAIL: begin
                     if (fsize == '0) begin
                        pkt_done = 1'b1;
                     end else if (err_code_n == ERR_NONE) begin
                        err_code_n = ERR_LEN;
                        err_hdr_n  = flit_i;
                     end
                  end
                  FT_HEAD: begin
                     if (fsize != '0) begin
                        state_d[v] = ST_PAYLOAD;
                        rem_d[v]   = fsize;
                        head_d[v]  = flit_i;
                     end else if (err_code_n == ERR_NONE) begin
                        err_code_n = ERR_LEN;
                        err_hdr_n  = flit_i;
                     end
                  end
                  default: begin
                     err_code_n = ERR_ORPHAN;
                     err_hdr_n  = flit_i;
                  end
               endcase
            end
         end
      end
   end

   always_comb begin
      flit_cnt_d = (accept && (flit_cnt_q != '1)) ? flit_cnt_q + 32'd1 : flit_cnt_q;
      pkt_cnt_d  = (pkt_done && (pkt_cnt_q != '1)) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      err_vc_d   = err_vc_q;
      err_hdr_d  = err_hdr_q;
      // A fresh error in the clearing cycle is captured rather than dropped.
      if ((err_code_n != ERR_NONE) && (!err_q || clr_i)) begin
         err_d      = 1'b1;
         err_code_d = err_code_n;
         err_vc_d   = vc_id_i;
         err_hdr_d  = err_hdr_n;
      end else if (clr_i) begin
         err_d      = 1'b0;
         err_code_d = ERR_NONE;
         err_vc_d   = '0;
         err_hdr_d  = '0;
      end
   end

   always_ff @(posedge clk_noc) begin
      if (arst_noc) begin
         ready_q    <= '0;
         flit_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         err_vc_q   <= '0;
         err_hdr_q  <= '0;
         for (int unsigned v = 0; v < N_VC; v++) begin
            state_q[v] <= ST_IDLE;
            rem_q[v]   <= '0;
            head_q[v]  <= '0;
         end
      end else begin
         ready_q    <= ready_d;
         flit_cnt_q <= flit_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         err_vc_q   <= err_vc_d;
         err_hdr_q  <= err_hdr_d;
         for (int unsigned v = 0; v < N_VC; v++) begin
            state_q[v] <= state_d[v];
            rem_q[v]   <= rem_d[v];
            head_q[v]  <= head_d[v];
         end
      end
   end

   assign ready_o    = ready_q;
   assign flit_cnt_o = flit_cnt_q;
   assign pkt_cnt_o  = pkt_cnt_q;
   assign err_o      = err_q;
   assign err_code_o = err_code_q;
   assign err_vc_o   = err_vc_q;
   assign err_hdr_o  = err_hdr_q;

endmodule

// File: tb/tb_ravenoc_edge_sink.sv
// Bench for ravenoc_edge_sink: directed framing scenarios plus random traffic, all
// outputs compared every cycle against a packet-level reference model.
module tb_ravenoc_edge_sink;

   logic        clk_noc = 1'b0;
   logic        arst_noc, en_i, clr_i, valid_i;
   logic [33:0] flit_i;
   logic [1:0]  vc_id_i;
   logic [2:0]  ready_o;
   logic [31:0] flit_cnt_o;
   logic [15:0] pkt_cnt_o;
   logic        err_o;
   logic [1:0]  err_code_o;
   logic [1:0]  err_vc_o;
   logic [33:0] err_hdr_o;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [2:0]  m_ready;
   logic [31:0] m_flits;
   logic [15:0] m_pkts;
   logic        m_err;
   logic [1:0]  m_code, m_vc;
   logic [33:0] m_hdr;
   bit          m_busy [3];
   int          m_rem  [3];
   logic [33:0] m_head [3];

   ravenoc_edge_sink #(.FLIT_WIDTH(34), .X_W(2), .Y_W(2), .PKT_W(8), .N_VC(3)) dut (
      .clk_noc(clk_noc), .arst_noc(arst_noc), .en_i(en_i), .clr_i(clr_i),
      .flit_i(flit_i), .valid_i(valid_i), .vc_id_i(vc_id_i), .ready_o(ready_o),
      .flit_cnt_o(flit_cnt_o), .pkt_cnt_o(pkt_cnt_o), .err_o(err_o),
      .err_code_o(err_code_o), .err_vc_o(err_vc_o), .err_hdr_o(err_hdr_o)
   );

   always #5 clk_noc = ~clk_noc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [33:0] mk(input logic [1:0] ty, input int sz);
      logic [19:0] payload;
      payload = 20'($urandom);
      return {ty, 2'($urandom), 2'($urandom), 8'(sz), payload};
   endfunction

   task automatic model_step();
      logic [1:0]  ty, ec;
      logic [33:0] eh;
      int          sz, vc;
      bit          was_busy;
      if (arst_noc) begin
         m_ready = '0; m_flits = '0; m_pkts = '0;
         m_err = 1'b0; m_code = '0; m_vc = '0; m_hdr = '0;
         for (int i = 0; i < 3; i++) begin
            m_busy[i] = 0; m_rem[i] = 0; m_head[i] = '0;
         end
         return;
      end
      ec = 2'd0; eh = '0;
      vc = int'(vc_id_i);
      if (valid_i && vc < 3 && m_ready[vc]) begin
         if (m_flits != 32'hFFFF_FFFF) m_flits++;
         ty = flit_i[33:32];
         sz = int'(flit_i[27:20]);
         was_busy = m_busy[vc];
         if (was_busy) begin
            m_busy[vc] = 0;
            if (ty == 2'b01) begin
               if (m_rem[vc] > 1) begin
                  m_rem[vc]--; m_busy[vc] = 1;
               end else begin
                  ec = 2'd3; eh = m_head[vc];
               end
            end else if (ty == 2'b10) begin
               if (m_rem[vc] == 1) begin
                  if (m_pkts != 16'hFFFF) m_pkts++;
               end else begin
                  ec = 2'd3; eh = m_head[vc];
               end
            end else begin
               ec = 2'd2; eh = m_head[vc];
            end
         end
         if (!was_busy || ec == 2'd2) begin
            if (ty == 2'b11) begin
               if (sz == 0) begin
                  if (m_pkts != 16'hFFFF) m_pkts++;
               end else if (ec == 2'd0) begin
                  ec = 2'd3; eh = flit_i;
               end
            end else if (ty == 2'b00) begin
               if (sz > 0) begin
                  m_busy[vc] = 1; m_rem[vc] = sz; m_head[vc] = flit_i;
               end else if (ec == 2'd0) begin
                  ec = 2'd3; eh = flit_i;
               end
            end else begin
               ec = 2'd1; eh = flit_i;
            end
         end
      end
      if (ec != 2'd0 && (!m_err || clr_i)) begin
         m_err = 1'b1; m_code = ec; m_vc = vc_id_i; m_hdr = eh;
      end else if (clr_i) begin
         m_err = 1'b0; m_code = '0; m_vc = '0; m_hdr = '0;
      end
      m_ready = en_i ? 3'b111 : 3'b000;
   endtask

   task automatic compare_all();
      check("ready_o", ready_o, m_ready);
      check("flit_cnt_o", flit_cnt_o, m_flits);
      check("pkt_cnt_o", pkt_cnt_o, m_pkts);
      check("err_o", err_o, m_err);
      check("err_code_o", err_code_o, m_code);
      check("err_vc_o", err_vc_o, m_vc);
      check("err_hdr_o", err_hdr_o, m_hdr);
   endtask

   task automatic tick();
      @(posedge clk_noc);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic send(input int vc, input logic [33:0] f);
      valid_i = 1'b1; vc_id_i = 2'(vc); flit_i = f;
      tick();
      valid_i = 1'b0;
   endtask

   logic [33:0] f, h;
   logic [31:0] fc;

   initial begin
      arst_noc = 1'b1; en_i = 1'b1; clr_i = 1'b0; valid_i = 1'b0;
      flit_i = '0; vc_id_i = '0;

      // 1: reset, then ready rises one cycle after release
      repeat (3) tick();
      arst_noc = 1'b0;
      tick();
      check("t1_ready", ready_o, 3'b111);
      check("t1_flits", flit_cnt_o, 0);
      check("t1_err", err_o, 0);

      // 2: clean three-flit packet on VC1
      send(1, mk(2'b00, 2));
      send(1, mk(2'b01, 0));
      send(1, mk(2'b10, 0));
      check("t2_pkts", pkt_cnt_o, 1);
      check("t2_flits", flit_cnt_o, 3);
      check("t2_err", err_o, 0);

      // 3: interleaved VC0 packet and VC2 single-flit packet
      send(0, mk(2'b00, 3));
      send(2, mk(2'b11, 0));
      send(0, mk(2'b01, 0));
      send(0, mk(2'b01, 0));
      send(0, mk(2'b10, 0));
      check("t3_pkts", pkt_cnt_o, 3);
      check("t3_err", err_o, 0);

      // 4: orphan body on idle VC0, later error does not overwrite
      f = mk(2'b01, 0);
      send(0, f);
      check("t4_err", err_o, 1);
      check("t4_code", err_code_o, 2'b01);
      check("t4_vc", err_vc_o, 0);
      check("t4_hdr", err_hdr_o, f);
      send(1, mk(2'b10, 0));
      check("t4_code_kept", err_code_o, 2'b01);
      check("t4_hdr_kept", err_hdr_o, f);

      // 5: truncated packet on VC2; new head-tail still counts
      clr_i = 1'b1; tick(); clr_i = 1'b0;
      check("t5_clr", err_o, 0);
      h = mk(2'b00, 3);
      send(2, h);
      send(2, mk(2'b01, 0));
      send(2, mk(2'b11, 0));
      check("t5_code", err_code_o, 2'b10);
      check("t5_vc", err_vc_o, 2);
      check("t5_hdr", err_hdr_o, h);
      check("t5_pkts", pkt_cnt_o, 4);

      // 6: clear coincident with a LEN error captures the new error
      h = mk(2'b00, 2);
      send(1, h);
      clr_i = 1'b1;
      send(1, mk(2'b10, 0));
      clr_i = 1'b0;
      check("t6_err", err_o, 1);
      check("t6_code", err_code_o, 2'b11);
      check("t6_vc", err_vc_o, 1);
      check("t6_hdr", err_hdr_o, h);

      // reset mid-packet returns the VC to idle
      send(0, mk(2'b00, 3));
      arst_noc = 1'b1; tick(); tick(); arst_noc = 1'b0;
      tick();
      send(0, mk(2'b11, 0));
      check("t6_rst_err", err_o, 0);
      check("t6_rst_pkts", pkt_cnt_o, 1);

      // enable falling: in-flight handshake accepted, next one refused
      en_i = 1'b0;
      send(0, mk(2'b11, 0));
      check("en_fall_pkts", pkt_cnt_o, 2);
      check("en_low_ready", ready_o, 3'b000);
      fc = flit_cnt_o;
      send(0, mk(2'b11, 0));
      check("en_low_hold", flit_cnt_o, fc);
      en_i = 1'b1; tick();

      // out-of-range VC never accepted
      send(3, mk(2'b11, 0));
      check("vc3_refused", flit_cnt_o, fc);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         en_i    = ($urandom % 8) != 0;
         clr_i   = ($urandom % 12) == 0;
         valid_i = ($urandom % 4) != 0;
         vc_id_i = 2'($urandom % 4);
         flit_i  = mk(2'($urandom), int'($urandom % 4));
         arst_noc = ($urandom % 500) == 0;
         tick();
      end
      arst_noc = 1'b0; valid_i = 1'b0; clr_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
